// File: rtl/maroc_dc_pkg.sv
// Shared definitions for the IM-mode data chain: packet FSM encoding,
// header layout and default frame geometry.
package maroc_dc_pkg;

    localparam int unsigned HDR_LEN         = 3;
    localparam int unsigned PAYLOAD_LEN_DEF = 256;
    localparam logic [15:0] SYNC_WORD_DEF   = 16'hAA55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_PAYLOAD
    } pkt_state_t;

endpackage

// File: rtl/im_frame_packetizer_if.sv
// Stream bundle for the packetizer: data, valid/ready handshake, last and
// first-of-frame markers. The source drives through master, the sink
// through slave.
interface im_frame_packetizer_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              first;

    modport master (output tdata, output tvalid, output tlast, output first, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input first, output tready);
endinterface

// File: rtl/im_sync_fifo.sv
// First-word-fall-through FIFO with registered occupancy, registered write
// ready and a synchronous clear that overrides push and pop.
module im_sync_fifo #(
    parameter  int unsigned WIDTH = 17,
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             wr_ready,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && wr_ready;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and write ready. Ready is registered from the next
    // occupancy so it drops on the same edge that fills the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            wr_ready <= (count_nxt != (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/im_frame_packetizer.sv
// Buffers the IM-mode pixel stream, prefixes each frame with a sync word and
// a 32-bit frame number, and emits complete packets on the output stream.
// Also checks the incoming frame length and framing markers.
module im_frame_packetizer
    import maroc_dc_pkg::*;
#(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       DEPTH       = 512,
    parameter int unsigned       PAYLOAD_LEN = PAYLOAD_LEN_DEF,
    parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(SYNC_WORD_DEF)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    im_frame_packetizer_if.slave          s_axis,
    im_frame_packetizer_if.master         m_axis,
    output logic [9:0]                    data_count,
    output logic                          len_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    pkt_state_t      state;
    logic [31:0]     frame_no;
    logic [15:0]     word_cnt;
    logic [15:0]     wr_idx;
    logic [DATA_W:0] fifo_rd;
    logic            fifo_empty;
    logic            fifo_ready;
    logic [AW:0]     fifo_count;
    logic            push;
    logic            pop;
    logic            head_last;

    assign push            = s_axis.tvalid && fifo_ready;
    assign s_axis.tready   = fifo_ready;
    assign head_last       = fifo_rd[DATA_W];
    assign pop             = (state == ST_PAYLOAD) && m_axis.tready && !fifo_empty;
    assign data_count      = 10'(fifo_count);
    assign wr_idx          = s_axis.first ? 16'd0 : word_cnt;

    im_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .push     (push),
        .pop      (pop),
        .wr_data  ({s_axis.tlast, s_axis.tdata}),
        .rd_data  (fifo_rd),
        .empty    (fifo_empty),
        .wr_ready (fifo_ready),
        .count    (fifo_count)
    );

    // Output decode from the registered state and the FIFO head only, so
    // m_tvalid never depends on m_tready.
    always_comb begin
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tlast  = 1'b0;
        m_axis.first  = 1'b0;
        case (state)
            ST_HDR0: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = SYNC_WORD;
            end
            ST_HDR1: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = DATA_W'(frame_no[15:0]);
            end
            ST_HDR2: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = DATA_W'(frame_no[31:16]);
            end
            ST_PAYLOAD: begin
                m_axis.tvalid = !fifo_empty;
                m_axis.tdata  = fifo_rd[DATA_W-1:0];
                m_axis.tlast  = !fifo_empty && head_last;
            end
            default: ;
        endcase
    end

    // Packet FSM and frame counter; clear aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            frame_no <= '0;
        end else if (clear) begin
            state    <= ST_IDLE;
            frame_no <= '0;
        end else begin
            case (state)
                ST_IDLE:    if (!fifo_empty)    state <= ST_HDR0;
                ST_HDR0:    if (m_axis.tready)  state <= ST_HDR1;
                ST_HDR1:    if (m_axis.tready)  state <= ST_HDR2;
                ST_HDR2:    if (m_axis.tready)  state <= ST_PAYLOAD;
                ST_PAYLOAD: begin
                    if (pop && head_last) begin
                        frame_no <= frame_no + 32'd1;
                        state    <= ST_IDLE;
                    end
                end
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Write-side length checker. The counter returns to zero after each
    // tlast, so a nonzero count at s_first means the previous frame never
    // closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            len_err  <= 1'b0;
        end else if (clear) begin
            word_cnt <= '0;
            len_err  <= 1'b0;
        end else if (push) begin
            if (s_axis.first && (word_cnt != '0)) begin
                len_err <= 1'b1;
            end
            if (s_axis.tlast && (wr_idx != 16'(PAYLOAD_LEN - 1))) begin
                len_err <= 1'b1;
            end
            word_cnt <= s_axis.tlast ? 16'd0 : wr_idx + 16'd1;
        end
    end

endmodule

// File: doc/im_frame_packetizer.md
# im_frame_packetizer

Buffers the 256-word imaging-mode pixel stream produced by the IM-mode sequencer, prepends a 3-word frame header and emits complete packets on an AXI-Stream master toward the Ethernet/DMA path. Its FIFO occupancy (`data_count`) feeds back to the sequencer, which starts a frame only when enough space remains.

## Interface
Parameters:
- `DATA_W`, 16: stream word width.
- `DEPTH`, 512: FIFO depth in words; power of two, ≥ 2×`PAYLOAD_LEN`.
- `PAYLOAD_LEN`, 256: expected payload words per frame.
- `SYNC_WORD`, 16'hAA55: header word 0.

Ports:
- `clk` in 1: single clock, all logic.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `clear` in 1: synchronous flush (shares `frame_reset` with the sequencer).
- `s_tdata` in `DATA_W`: muxed pixel word.
- `s_tvalid` in 1: upstream word valid.
- `s_tlast` in 1: last payload word of the frame.
- `s_first` in 1: first payload word of the frame.
- `s_tready` out 1: FIFO can accept a word.
- `data_count` out 10: current FIFO occupancy, 0..`DEPTH`.
- `m_tdata` out `DATA_W`, `m_tvalid` out 1, `m_tlast` out 1, `m_tready` in 1: packet output stream.
- `len_err` out 1: sticky; a frame had a length ≠ `PAYLOAD_LEN` or `s_first` arrived mid-frame.

## Operation
- Write side: push {`s_tlast`, `s_tdata`} when `s_tvalid && s_tready`; `s_tready = !full`.
- Write-side length check: a word counter clears on `s_first` and increments per push. `s_tlast` with count ≠ `PAYLOAD_LEN-1` sets `len_err`. `s_first` while the counter is nonzero and the previous `s_tlast` has not been seen also sets `len_err`. The data is still stored.
- Output FSM states are IDLE, HDR0, HDR1, HDR2, PAYLOAD.
  - IDLE: go to HDR0 when the FIFO is non-empty.
  - HDRn: `m_tdata` = `SYNC_WORD` / `frame_no[15:0]` / `frame_no[31:16]`; advance on `m_tready`.
  - PAYLOAD: `m_tdata` = FIFO head; pop on `m_tready`. When the popped word has its last bit set, assert `m_tlast`, increment `frame_no` and return to IDLE.
- `m_tvalid` = 1 in all HDR states; in PAYLOAD it equals FIFO non-empty. Holes are allowed; data and `m_tlast` stay stable while `m_tvalid && !m_tready`.
- `frame_no` is a 32-bit counter that wraps 0xFFFFFFFF→0.
- A simultaneous push and pop leaves `data_count` unchanged. Pushing into a full FIFO cannot happen because `s_tready` = 0.
- `clear`: FIFO emptied, FSM to IDLE, `frame_no` = 0, word counter = 0, `len_err` = 0. It takes priority over a push or pop in the same cycle and aborts a packet in progress without emitting `m_tlast`.

## Timing
- Reset (`rst_n` low) values: `s_tready` = 1, `data_count` = 0, `m_tvalid` = 0, `m_tlast` = 0, `m_tdata` = 0, `len_err` = 0, state IDLE, `frame_no` = 0.
- FIFO is first-word-fall-through, and `data_count` is registered.
  - A push at edge N makes `data_count` +1 after edge N.
  - A push at edge N lets the FSM leave IDLE at edge N+1, so HDR0 is valid after edge N+1.
- With `m_tready` held high, a frame takes 3 + `PAYLOAD_LEN` consecutive beats.
- `s_tready` is registered from the full flag; its deassertion is visible the cycle after the FIFO becomes full.
- Output signals are driven from registers or from the FSM state plus the FIFO read port only; there are no combinational paths from `m_tready` to `m_tvalid`.

## Structure
- Shared package `maroc_dc_pkg` holds the FSM state encoding, `SYNC_WORD` default, `HDR_LEN` = 3, and `PAYLOAD_LEN` default (shared with the sequencer).
- Sub-module `im_sync_fifo` is a FWFT FIFO of width `DATA_W+1`, depth `DEPTH`, with occupancy output and synchronous clear. The top level holds the header FSM, frame counter and length checker.

## Test plan
- Single frame, `m_tready` = 1: push 256 words 0..255 → output AA55, 0000, 0000, 0..255; `m_tlast` on word 255 only; `frame_no` becomes 1; `len_err` = 0.
- Backpressure: toggle `m_tready` randomly across 3 frames → output content is identical to the no-stall case, `m_tdata` is stable during stalls, headers carry frame numbers 0, 1, 2.
- Fill: hold `m_tready` = 0 and push → `data_count` reaches 512 and `s_tready` drops; release → the FIFO drains and `data_count` returns to 0.
- Short frame: `s_tlast` on word 100 → `len_err` = 1 (sticky); the 101-word packet is still emitted with `m_tlast`.
- `clear` mid-PAYLOAD (after 50 words out) → next cycle `m_tvalid` = 0, `data_count` = 0; the next frame's header shows `frame_no` 0.
- Async reset while streaming: assert `rst_n` low mid-cycle → all outputs immediately take their reset values.
